// File: rtl/ddr3_req_arbiter_if.sv
// Requester and DDR3 application-interface bundle for ddr3_req_arbiter.
// The arbiter uses the master modport; the requesters and the controller side use slave.
interface ddr3_req_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int REQ_AW = 16
);
   logic              I_calib_done;
   logic              I_wr_valid;
   logic              O_wr_ready;
   logic [REQ_AW-1:0] I_wr_addr;
   logic [47:0]       I_wr_data;
   logic              I_rd_valid;
   logic              O_rd_ready;
   logic [REQ_AW-1:0] I_rd_addr;
   logic              I_app_cmd_rdy;
   logic              I_app_wdf_rdy;
   logic              O_app_en;
   logic [2:0]        O_app_cmd;
   logic [ADDR_W-1:0] O_app_addr;
   logic              O_app_wdf_wren;
   logic              O_app_wdf_end;
   logic [63:0]       O_app_wdf_data;
   logic              I_app_rd_valid;
   logic              I_app_rd_end;
   logic [3:0]        O_rd_outstanding;

   modport master (
      input  I_calib_done,
      input  I_wr_valid, I_wr_addr, I_wr_data,
      output O_wr_ready,
      input  I_rd_valid, I_rd_addr,
      output O_rd_ready,
      input  I_app_cmd_rdy, I_app_wdf_rdy,
      output O_app_en, O_app_cmd, O_app_addr,
      output O_app_wdf_wren, O_app_wdf_end, O_app_wdf_data,
      input  I_app_rd_valid, I_app_rd_end,
      output O_rd_outstanding
   );

   modport slave (
      output I_calib_done,
      output I_wr_valid, I_wr_addr, I_wr_data,
      input  O_wr_ready,
      output I_rd_valid, I_rd_addr,
      input  O_rd_ready,
      output I_app_cmd_rdy, I_app_wdf_rdy,
      input  O_app_en, O_app_cmd, O_app_addr,
      input  O_app_wdf_wren, O_app_wdf_end, O_app_wdf_data,
      output I_app_rd_valid, I_app_rd_end,
      input  O_rd_outstanding
   );
endinterface

// File: rtl/ddr3_req_arbiter.sv
// Round-robin arbiter sharing the DDR3 app interface between the pixel write and backlight read channels.
// Optional statistics counters are compiled in when ARB_STATS_EN is defined.
module ddr3_req_arbiter #(
   parameter int ADDR_W     = 28,
   parameter int REQ_AW     = 16,
   parameter int MAX_RD_OUT = 4
) (
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   ddr3_req_arbiter_if.master    bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]           O_wr_grants,
   output logic [15:0]           O_rd_grants,
   output logic [15:0]           O_stall_cycles
`endif
);

   localparam logic [3:0] MAX_RD_OUT_C = 4'(MAX_RD_OUT);
   localparam int         PAD_W        = ADDR_W - REQ_AW - 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              wr_full_q, wr_full_d;
   logic              rd_full_q, rd_full_d;
   logic              cmd_done_q, cmd_done_d;
   logic              data_done_q, data_done_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [3:0]        rd_out_q, rd_out_d;
   logic [REQ_AW-1:0] wr_addr_q, wr_addr_d;
   logic [REQ_AW-1:0] rd_addr_q, rd_addr_d;
   logic [47:0]       wr_data_q, wr_data_d;

   logic              wr_load, rd_load;
   logic              wr_elig, rd_elig;
   logic              wr_complete, rd_inc, rd_dec;
   logic              cmd_fin, data_fin;
   logic              app_en, wdf_wren;
   logic [2:0]        app_cmd;
   logic [ADDR_W-1:0] app_addr;
   logic [63:0]       wdf_data;

   assign wr_load = bus.I_wr_valid && !wr_full_q;
   assign rd_load = bus.I_rd_valid && !rd_full_q;
   assign wr_elig = wr_full_q;
   assign rd_elig = rd_full_q && (rd_out_q < MAX_RD_OUT_C);
   assign rd_dec  = bus.I_app_rd_valid && bus.I_app_rd_end && (rd_out_q != 4'd0);

   always_comb begin
      state_d     = state_q;
      cmd_done_d  = cmd_done_q;
      data_done_d = data_done_q;
      rr_ptr_d    = rr_ptr_q;
      wr_complete = 1'b0;
      rd_inc      = 1'b0;
      cmd_fin     = 1'b0;
      data_fin    = 1'b0;
      app_en      = 1'b0;
      app_cmd     = 3'b000;
      app_addr    = '0;
      wdf_wren    = 1'b0;
      wdf_data    = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.I_calib_done) begin
               if (wr_elig && (!rd_elig || !rr_ptr_q)) begin
                  state_d  = ST_WR;
                  rr_ptr_d = 1'b1;
               end else if (rd_elig) begin
                  state_d  = ST_RD;
                  rr_ptr_d = 1'b0;
               end
            end
         end

         ST_WR: begin
            app_en   = !cmd_done_q;
            app_cmd  = 3'b000;
            app_addr = {{PAD_W{1'b0}}, wr_addr_q, 3'b000};
            wdf_wren = !data_done_q;
            wdf_data = {16'h0000, wr_data_q};
            // Command and data handshakes are independent; each may finish first.
            cmd_fin  = cmd_done_q || bus.I_app_cmd_rdy;
            data_fin = data_done_q || bus.I_app_wdf_rdy;
            if (cmd_fin && data_fin) begin
               wr_complete = 1'b1;
               cmd_done_d  = 1'b0;
               data_done_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               cmd_done_d  = cmd_fin;
               data_done_d = data_fin;
            end
         end

         ST_RD: begin
            app_en   = 1'b1;
            app_cmd  = 3'b001;
            app_addr = {{PAD_W{1'b0}}, rd_addr_q, 3'b000};
            if (bus.I_app_cmd_rdy) begin
               rd_inc  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_full_d = wr_full_q;
      rd_full_d = rd_full_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      rd_out_d  = rd_out_q;

      // A load only happens while empty, so it never collides with a clear.
      if (wr_load) begin
         wr_full_d = 1'b1;
         wr_addr_d = bus.I_wr_addr;
         wr_data_d = bus.I_wr_data;
      end else if (wr_complete) begin
         wr_full_d = 1'b0;
      end

      if (rd_load) begin
         rd_full_d = 1'b1;
         rd_addr_d = bus.I_rd_addr;
      end else if (rd_inc) begin
         rd_full_d = 1'b0;
      end

      case ({rd_inc, rd_dec})
         2'b10:   rd_out_d = rd_out_q + 4'd1;
         2'b01:   rd_out_d = rd_out_q - 4'd1;
         default: rd_out_d = rd_out_q;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q     <= ST_IDLE;
         wr_full_q   <= 1'b0;
         rd_full_q   <= 1'b0;
         cmd_done_q  <= 1'b0;
         data_done_q <= 1'b0;
         rr_ptr_q    <= 1'b0;
         rd_out_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         wr_full_q   <= wr_full_d;
         rd_full_q   <= rd_full_d;
         cmd_done_q  <= cmd_done_d;
         data_done_q <= data_done_d;
         rr_ptr_q    <= rr_ptr_d;
         rd_out_q    <= rd_out_d;
      end
   end

   // Payload registers are qualified by the full flags, so they need no reset.
   always_ff @(posedge I_clk) begin
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
   end

   assign bus.O_wr_ready       = !wr_full_q;
   assign bus.O_rd_ready       = !rd_full_q;
   assign bus.O_app_en         = app_en;
   assign bus.O_app_cmd        = app_cmd;
   assign bus.O_app_addr       = app_addr;
   assign bus.O_app_wdf_wren   = wdf_wren;
   assign bus.O_app_wdf_end    = wdf_wren;
   assign bus.O_app_wdf_data   = wdf_data;
   assign bus.O_rd_outstanding = rd_out_q;

`ifdef ARB_STATS_EN
   logic [15:0] wr_grants_q, wr_grants_d;
   logic [15:0] rd_grants_q, rd_grants_d;
   logic [15:0] stall_q, stall_d;

   always_comb begin
      wr_grants_d = wr_grants_q + 16'(wr_complete);
      rd_grants_d = rd_grants_q + 16'(rd_inc);
      stall_d     = stall_q + 16'(app_en && !bus.I_app_cmd_rdy);
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         wr_grants_q <= 16'd0;
         rd_grants_q <= 16'd0;
         stall_q     <= 16'd0;
      end else begin
         wr_grants_q <= wr_grants_d;
         rd_grants_q <= rd_grants_d;
         stall_q     <= stall_d;
      end
   end

   assign O_wr_grants    = wr_grants_q;
   assign O_rd_grants    = rd_grants_q;
   assign O_stall_cycles = stall_q;
`endif

endmodule

// File: doc/ddr3_req_arbiter.md
# ddr3_req_arbiter

Shares the single DDR3 application (user) interface between two requesters:
- the pixel-path write channel, which carries gray-scale words for each line group;
- the backlight read channel, which fetches zone data for the LED buffer.

The block sits between the write/read address generators and the DDR3 controller IP. It holds one pending request per channel and grants the channels in round-robin order. It builds the application command, address and data beats, and it limits the number of outstanding reads.

## Interface
Parameters:
- ADDR_W, 28, width of app_addr
- REQ_AW, 16, width of requester word address
- MAX_RD_OUT, 4, max outstanding read commands (1..15)

Ports:
- I_clk  in  1  controller user clock (clk_x1 domain); all logic on rising edge
- I_rst_n  in  1  asynchronous, active-low reset
- I_calib_done  in  1  DDR3 init/calibration complete
- I_wr_valid  in  1  write request valid
- O_wr_ready  out  1  write holding register empty
- I_wr_addr  in  REQ_AW  write word address
- I_wr_data  in  48  write payload
- I_rd_valid  in  1  read request valid
- O_rd_ready  out  1  read holding register empty
- I_rd_addr  in  REQ_AW  read word address
- I_app_cmd_rdy  in  1  controller accepts command
- I_app_wdf_rdy  in  1  controller accepts write data
- O_app_en  out  1  command strobe
- O_app_cmd  out  3  3'b000 write, 3'b001 read
- O_app_addr  out  ADDR_W  {zeros, addr, 3'b000}
- O_app_wdf_wren  out  1  write-data strobe
- O_app_wdf_end  out  1  equals O_app_wdf_wren (single-beat)
- O_app_wdf_data  out  64  {16'h0000, wr_data}
- I_app_rd_valid  in  1  read data beat valid
- I_app_rd_end  in  1  last beat of a read burst
- O_rd_outstanding  out  4  reads issued, not yet completed

## Operation
- **Holding registers.**
  - Each channel has a one-entry holding register; ready = !full.
  - A request loads on the edge where valid&&ready. The register clears when its command completes.
- **FSM states.** IDLE, WR, RD.
- **IDLE.** Grants only when I_calib_done=1.
  - Write eligible: write hold full.
  - Read eligible: read hold full and O_rd_outstanding < MAX_RD_OUT.
  - One eligible → grant it. Both eligible → grant the channel named by rr_ptr.
- **Round-robin pointer.**
  - rr_ptr is 0 = write, 1 = read; reset value 0.
  - On each grant, rr_ptr points to the other channel.
- **WR.** O_app_en=1, O_app_cmd=000, O_app_wdf_wren=1.
  - cmd_done sets on I_app_cmd_rdy; data_done sets on I_app_wdf_rdy.
  - Each strobe drops once its own flag has set.
  - When both flags are set, or both are set in the same cycle: clear write hold, clear flags, go to IDLE.
- **RD.** O_app_en=1, O_app_cmd=001.
  - On I_app_cmd_rdy: increment the outstanding counter, clear read hold, go to IDLE.
- **Outstanding counter.**
  - Decrements on I_app_rd_valid && I_app_rd_end.
  - If an increment and a decrement happen in the same cycle, the counter is unchanged.
  - Saturates at 0; a spurious end at 0 is ignored.
- **Address.** O_app_addr = {(ADDR_W-REQ_AW-3)'b0, addr, 3'b000}. Each request is one 8-word BL8 burst, 64-bit beat.
- **Calibration loss.** If I_calib_done drops outside IDLE, the current command completes; no new grant is made.

## Timing
- **Reset values.** O_wr_ready=1, O_rd_ready=1, every other output 0, FSM in IDLE.
- **Latency.** Request accepted at edge N → FSM leaves IDLE at edge N+1 → O_app_en high in cycle N+1..N+2. Minimum latency is 1 cycle.
- **Command hold.** O_app_en, O_app_cmd, O_app_addr and data stay stable until accepted.
- **Back-to-back grants.** IDLE lasts one cycle between grants, so sustained throughput is one command per 2 cycles.
- **Ready release.** O_*_ready returns to 1 on the edge after the completing handshake. A new request may load that cycle.
- **Reset mid-operation.** Holds, flags and the counter clear immediately; the in-flight command is dropped.

## Configuration
- **ARB_STATS_EN defined.** Adds three outputs, O_wr_grants[15:0], O_rd_grants[15:0] and O_stall_cycles[15:0].
  - O_wr_grants and O_rd_grants count each completed command.
  - O_stall_cycles counts cycles with O_app_en=1 && !I_app_cmd_rdy.
  - All three wrap at 16'hFFFF→0 and reset to 0.
- **ARB_STATS_EN undefined.** These ports and counters are absent; all other behaviour is identical.

## Test plan
- **Calibration gating.** Hold I_calib_done=0 and issue one write.
  - O_wr_ready drops; O_app_en stays 0.
  - Raise calib: app_en appears 1 cycle later with addr = req_addr<<3.
- **Write handshake split.** Write I_wr_addr=16'h0012, data=48'hA5A5_0000_1234.
  - Hold wdf_rdy low for 3 cycles and cmd_rdy high.
  - Required: app_en drops after 1 cycle; wdf_wren is held 4 cycles with data 64'h0000_A5A5_0000_1234; then IDLE.
- **Round-robin.** Keep both channels continuously valid.
  - Commands alternate W,R,W,R starting with W after reset.
- **Read limit.** Issue 6 reads with MAX_RD_OUT=4 and no rd_end.
  - Exactly 4 read commands issue and O_rd_outstanding=4; writes still proceed.
  - One rd_end releases the 5th read.
- **Simultaneous events.** Assert a read cmd accept and rd_valid&&rd_end in the same cycle.
  - The counter is unchanged.
- **Reset mid-operation.** Assert I_rst_n low during WR with cmd accepted but data pending.
  - All outputs take their reset values; after release, no residual wdf_wren appears.
